pll_lock_supervisor: RTL
========================

// Module: pll_lock_supervisor
// PURPOSE
//  Downstream companion to the PLL wrapper: drives PLL reset, watches lock, releases system reset.
//  Runs on the free-running PLL reference clock (50 MHz).
//  Synchronises pll_lock, pulses pll_rst and waits for lock with a timeout.
//  Requires a stable-lock window before releasing sys_rst; re-resets the PLL on lock loss.
// PARAMETERS
//  RST_CYCLES     16     cycles pll_rst is held high per attempt (>=1)
//  LOCK_TIMEOUT   50000  cycles allowed in WAIT_LOCK before retry (1 ms @ 50 MHz)
//  STABLE_CYCLES  1024   consecutive synced-lock cycles required before RUN (>=1)
//  MAX_RETRY      7      timeouts tolerated before FAIL (1..15)
//  SYNC_STAGES    2      flops in the pll_lock synchroniser (>=2)
// PORTS
//  clk        in   1  reference clock, same net as PLL clkin1
//  rst        in   1  synchronous, active-high reset
//  pll_lock   in   1  PLL lock, asynchronous to clk
//  pll_rst    out  1  PLL reset request, active-high
//  sys_rst    out  1  reset to PLL-clocked logic, active-high
//  locked_ok  out  1  high only in RUN
//  fail       out  1  sticky: retries exhausted
//  retry_cnt  out  4  timeouts since last RUN entry
//  state      out  3  0 PLL_RST, 1 WAIT_LOCK, 2 STABLE, 3 RUN, 4 FAIL
// BEHAVIOUR
//  - One clock domain: clk. Reset is synchronous and active-high (rst).
//  - Reset values: state=PLL_RST, pll_rst=1, sys_rst=1, locked_ok=0, fail=0,
//    retry_cnt=0, cycle counter=0, synchroniser flops=0.
//  - lock_s = pll_lock delayed SYNC_STAGES clk cycles. All decisions use lock_s only.
//  - All outputs are registered and change on the same edge as state.
//    pll_rst=(state==PLL_RST); sys_rst=(state!=RUN); locked_ok=(state==RUN); fail=(state==FAIL).
//  - Single cycle counter, cleared on every state change. Width = clog2 of the largest limit.
//  - PLL_RST: held exactly RST_CYCLES cycles, then -> WAIT_LOCK. lock_s is ignored.
//  - WAIT_LOCK:
//    - lock_s=1 -> STABLE.
//    - Otherwise, when counter==LOCK_TIMEOUT-1: retry_cnt+1.
//      - If the new value ==MAX_RETRY -> FAIL.
//      - Else -> PLL_RST.
//  - STABLE:
//    - lock_s=0 -> WAIT_LOCK. Timeout window restarts; retry_cnt unchanged.
//    - counter==STABLE_CYCLES-1 with lock_s=1 -> RUN, and retry_cnt cleared to 0.
//  - RUN: lock_s=0 (any single cycle) -> PLL_RST. sys_rst=1 and pll_rst=1 on that same edge.
//  - FAIL: terminal until rst. pll_rst=0, sys_rst=1. pll_lock is ignored.
//  - lock_s rising and timeout in the same cycle: lock wins (-> STABLE).
//  - rst mid-operation: everything returns to reset values on the next edge.
//    pll_rst is therefore reasserted at once.
//  - retry_cnt never wraps; it is bounded by MAX_RETRY.
// CONFIGURATION
//  `define LOCK_LOSS_CNT_EN:
//    - Adds output loss_cnt [7:0], reset 0.
//    - loss_cnt increments on each RUN->PLL_RST transition and saturates at 255.
//    - Only rst clears it.
//  Without the macro: no loss_cnt port, no counter logic; all other behaviour identical.
// TESTING (bench params RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=2, SYNC_STAGES=2)
//  1. Clean start:
//     - Stimulus: pll_lock rises 10 cycles after rst release and stays high.
//     - Response: pll_rst high 4 cycles; lock_s at +2; STABLE 8 cycles; then RUN.
//     - In RUN: sys_rst=0, locked_ok=1, retry_cnt=0.
//  2. Timeout retry:
//     - Stimulus: pll_lock held 0.
//     - Response: after 4+20 cycles retry_cnt=1 and pll_rst re-pulses 4 cycles.
//     - Second timeout -> state=4, fail=1, pll_rst=0, sys_rst=1. Remains so for 100 further cycles.
//  3. Glitch in STABLE:
//     - Stimulus: lock drops for 1 cycle at STABLE count 5.
//     - Response: state -> WAIT_LOCK then back to STABLE; count restarts; RUN reached 8 cycles after re-lock.
//     - retry_cnt unchanged throughout.
//  4. Loss in RUN:
//     - Stimulus: in RUN, pll_lock=0 for 1 cycle.
//     - Response: 2 cycles later sys_rst=1 and pll_rst=1 on the same edge; state=0.
//     - Sequence recovers to RUN. With LOCK_LOSS_CNT_EN: loss_cnt=1.
//  5. Simultaneous lock/timeout:
//     - Stimulus: lock_s rises exactly at counter=19.
//     - Response: -> STABLE; retry_cnt not incremented.
//  6. rst mid-STABLE:
//     - Stimulus: assert rst for 1 cycle.
//     - Response: next edge pll_rst=1, sys_rst=1, retry_cnt=0, state=0.
//     - With LOCK_LOSS_CNT_EN: loss_cnt=0.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: drives PLL reset, waits for a synchronised lock with a
// timeout, requires a stable-lock window before releasing sys_rst, and
// re-resets the PLL whenever lock is lost in RUN.
// Optional feature: define LOCK_LOSS_CNT_EN to add the saturating loss_cnt
// output that counts RUN->PLL_RST transitions.
module pll_lock_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 7,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       locked_ok,
    output logic       fail,
    output logic [3:0] retry_cnt,
`ifdef LOCK_LOSS_CNT_EN
    output logic [7:0] loss_cnt,
`endif
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    // One shared counter sized for the longest dwell limit.
    localparam int MAX_A  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_L  = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int CW     = (MAX_L > 1) ? $clog2(MAX_L) : 1;
    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_LIM = 4'(MAX_RETRY);

    state_t                 st, nxt;
    logic [CW-1:0]          cnt;
    logic [3:0]             retry_nxt;
    logic [3:0]             retry_inc;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;

    assign lock_s    = sync_q[SYNC_STAGES-1];
    assign retry_inc = retry_cnt + 4'd1;
    assign state     = st;

    // Multi-flop synchroniser for the asynchronous PLL lock.
    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
    end

    // Next-state and retry decision; a lock seen on the timeout cycle wins.
    always_comb begin
        nxt       = st;
        retry_nxt = retry_cnt;
        case (st)
            PLL_RST:   if (cnt == RST_LAST) nxt = WAIT_LOCK;
            WAIT_LOCK: begin
                if (lock_s) begin
                    nxt = STABLE;
                end else if (cnt == TO_LAST) begin
                    retry_nxt = retry_inc;
                    nxt       = (retry_inc == RETRY_LIM) ? FAIL : PLL_RST;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    nxt = WAIT_LOCK;
                end else if (cnt == STB_LAST) begin
                    nxt       = RUN;
                    retry_nxt = 4'd0;
                end
            end
            RUN:     if (!lock_s) nxt = PLL_RST;
            FAIL:    nxt = FAIL;
            default: nxt = PLL_RST;
        endcase
    end

    // State, dwell counter and outputs all update from the next state on one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= PLL_RST;
            cnt       <= '0;
            retry_cnt <= 4'd0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            locked_ok <= 1'b0;
            fail      <= 1'b0;
        end else begin
            st        <= nxt;
            retry_cnt <= retry_nxt;
            if (nxt != st)
                cnt <= '0;
            else if (st == PLL_RST || st == WAIT_LOCK || st == STABLE)
                cnt <= cnt + 1'b1;
            pll_rst   <= (nxt == PLL_RST);
            sys_rst   <= (nxt != RUN);
            locked_ok <= (nxt == RUN);
            fail      <= (nxt == FAIL);
        end
    end

`ifdef LOCK_LOSS_CNT_EN
    // Saturating count of lock losses while running; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst)
            loss_cnt <= 8'd0;
        else if (st == RUN && nxt == PLL_RST && loss_cnt != 8'hFF)
            loss_cnt <= loss_cnt + 8'd1;
    end
`endif

endmodule
